addr_reg_file: RTL and testbench

- Parametrised successor to the fixed PC/SP/LR/TX address-register set in the memory block.
- Holds NREGS address-width pointer registers, all equivalent and any of them selectable onto the address bus.
- Each register has per-access addressing modes (plain, post-increment, pre-decrement, silent increment) and byte-wise transfer to and from the data bus.
- Register 0 is the program counter by convention; the others serve as stack pointer, link register, transfer register and extra pointers.

---
 rtl/addr_reg_file.sv | 141 ++++++++++++++
 tb/tb_addr_reg_file.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/addr_reg_file.sv
// Bank of NREGS address-width pointer registers with counted abus access and byte-wise mbus transfer.
// Optional sticky count-wrap flag is built when ADDR_REG_WRAP_FAULT_EN is defined.
module addr_reg_file #(
  parameter int unsigned     DW        = 8,
  parameter int unsigned     NREGS     = 6,
  parameter int unsigned     SW        = 3,
  parameter logic [2*DW-1:0] RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [2*DW-1:0]   abus,
  inout  wire  [DW-1:0]     mbus,
  input  logic              aout_en,
  input  logic [SW-1:0]     aout_sel,
  input  logic [1:0]        aout_mode,
  input  logic              aload_en,
  input  logic [SW-1:0]     aload_sel,
  input  logic              mout_en,
  input  logic [SW-1:0]     mout_sel,
  input  logic              mout_hi,
  input  logic              mload_en,
  input  logic [SW-1:0]     mload_sel,
  input  logic              mload_hi,
  output logic [2*DW-1:0]   pc,
  output logic              wrap_fault
);

  localparam int unsigned AW = 2 * DW;

  localparam logic [1:0] MODE_PLAIN = 2'd0;
  localparam logic [1:0] MODE_PREDEC = 2'd2;
  localparam logic [1:0] MODE_INC = 2'd3;

  logic [AW-1:0] regs     [NREGS];
  logic [AW-1:0] regs_nxt [NREGS];

  logic          a_hit_c;
  logic [AW-1:0] a_rd_c;
  logic [AW-1:0] a_drv_c;
  logic          a_drive_c;
  logic [AW-1:0] m_rd_c;
  logic [DW-1:0] m_drv_c;
  logic          m_drive_c;
  logic          a_cnt_c;

  // Read muxes; unmatched (out-of-range) selects read as zero.
  always_comb begin
    a_hit_c = 1'b0;
    a_rd_c  = '0;
    m_rd_c  = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (aout_sel == SW'(i)) begin
        a_hit_c = 1'b1;
        a_rd_c  = regs[i];
      end
      if (mout_sel == SW'(i)) begin
        m_rd_c = regs[i];
      end
    end
  end

  always_comb begin
    a_drv_c = '0;
    if (a_hit_c) begin
      a_drv_c = (aout_mode == MODE_PREDEC) ? (a_rd_c - AW'(1)) : a_rd_c;
    end
  end

  assign m_drv_c   = mout_hi ? m_rd_c[AW-1:DW] : m_rd_c[DW-1:0];
  assign a_drive_c = aout_en && (aout_mode != MODE_INC) && !rst;
  assign m_drive_c = mout_en && !rst;

  assign abus = a_drive_c ? a_drv_c : {AW{1'bz}};
  assign mbus = m_drive_c ? m_drv_c : {DW{1'bz}};

  assign a_cnt_c = aout_en && (aout_mode != MODE_PLAIN);

  // Per-register next state: full load beats byte load beats count.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_nxt[i] = regs[i];
      if (aload_en && (aload_sel == SW'(i))) begin
        regs_nxt[i] = abus;
      end else if (mload_en && (mload_sel == SW'(i))) begin
        if (mload_hi) begin
          regs_nxt[i][AW-1:DW] = mbus;
        end else begin
          regs_nxt[i][DW-1:0] = mbus;
        end
      end else if (a_cnt_c && (aout_sel == SW'(i))) begin
        regs_nxt[i] = (aout_mode == MODE_PREDEC) ? (regs[i] - AW'(1)) : (regs[i] + AW'(1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      regs[0] <= RESET_VEC;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= regs_nxt[i];
      end
    end
  end

  assign pc = regs[0];

`ifdef ADDR_REG_WRAP_FAULT_EN
  logic wrap_set_c;

  // A wrap only counts when the count actually lands (not overridden by a load).
  always_comb begin
    wrap_set_c = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (a_cnt_c && (aout_sel == SW'(i))
          && !(aload_en && (aload_sel == SW'(i)))
          && !(mload_en && (mload_sel == SW'(i)))) begin
        if (aout_mode == MODE_PREDEC) begin
          wrap_set_c = wrap_set_c | (regs[i] == '0);
        end else begin
          wrap_set_c = wrap_set_c | (&regs[i]);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_fault <= 1'b0;
    end else if (wrap_set_c) begin
      wrap_fault <= 1'b1;
    end
  end
`else
  assign wrap_fault = 1'b0;
`endif

endmodule

// File: tb/tb_addr_reg_file.sv
// Scoreboarded bench for addr_reg_file: stimulus queues expected bus/pc values, a negedge monitor checks them.
module tb_addr_reg_file;

  localparam int S_ABUS = 0;
  localparam int S_MBUS = 1;
  localparam int S_PC   = 2;
  localparam int S_WRAP = 3;

`ifdef ADDR_REG_WRAP_FAULT_EN
  localparam logic WRAP_ON = 1'b1;
`else
  localparam logic WRAP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  wire  [15:0] abus;
  wire  [7:0]  mbus;
  logic        aout_en, aload_en, mout_en, mout_hi, mload_en, mload_hi;
  logic [2:0]  aout_sel, aload_sel, mout_sel, mload_sel;
  logic [1:0]  aout_mode;
  logic [15:0] pc;
  logic        wrap_fault;
  logic        tb_men;
  logic [7:0]  tb_mval;

  // Released abus floats high, released mbus floats low.
  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (abus[g]);
  end
  for (genvar g = 0; g < 8; g++) begin : g_pd
    pulldown (mbus[g]);
  end

  assign mbus = tb_men ? tb_mval : 8'hzz;

  addr_reg_file #(
    .DW(8), .NREGS(6), .SW(3), .RESET_VEC(16'h8000)
  ) dut (
    .clk(clk), .rst(rst), .abus(abus), .mbus(mbus),
    .aout_en(aout_en), .aout_sel(aout_sel), .aout_mode(aout_mode),
    .aload_en(aload_en), .aload_sel(aload_sel),
    .mout_en(mout_en), .mout_sel(mout_sel), .mout_hi(mout_hi),
    .mload_en(mload_en), .mload_sel(mload_sel), .mload_hi(mload_hi),
    .pc(pc), .wrap_fault(wrap_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          sig;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] mon_act;
  int          n_vec  = 0;
  int          n_miss = 0;

  task automatic expect_v(input string nm, input int sig, input logic [15:0] v);
    exp_t e;
    e.cyc  = cyc;
    e.sig  = sig;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic idle();
    aout_en = 1'b0; aout_sel = 3'd0; aout_mode = 2'd0;
    aload_en = 1'b0; aload_sel = 3'd0;
    mout_en = 1'b0; mout_sel = 3'd0; mout_hi = 1'b0;
    mload_en = 1'b0; mload_sel = 3'd0; mload_hi = 1'b0;
    tb_men = 1'b0; tb_mval = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic aout(input logic [2:0] s, input logic [1:0] m);
    aout_en = 1'b1; aout_sel = s; aout_mode = m;
  endtask

  task automatic mout(input logic [2:0] s, input logic hi);
    mout_en = 1'b1; mout_sel = s; mout_hi = hi;
  endtask

  task automatic mload(input logic [2:0] s, input logic hi, input logic [7:0] v);
    mload_en = 1'b1; mload_sel = s; mload_hi = hi; tb_men = 1'b1; tb_mval = v;
  endtask

  // Monitor: every entry queued for this cycle is compared mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      case (mon_e.sig)
        S_ABUS:  mon_act = abus;
        S_MBUS:  mon_act = {8'h00, mbus};
        S_PC:    mon_act = pc;
        default: mon_act = {15'h0000, wrap_fault};
      endcase
      n_vec++;
      if (mon_e.cyc != cyc || mon_act !== mon_e.val) begin
        n_miss++;
        $display("FAIL %s: got %h, expected %h (cycle %0d)", mon_e.name, mon_act, mon_e.val, cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #2 rst = 1'b1;

    // Reset held: bus drives must stay released even with enables on.
    tick(); aout(3'd0, 2'd0); mout(3'd0, 1'b1);
    expect_v("rst_pc", S_PC, 16'h8000);
    expect_v("rst_abus_z", S_ABUS, 16'hffff);
    expect_v("rst_mbus_z", S_MBUS, 16'h0000);
    expect_v("rst_wrap", S_WRAP, 16'h0000);

    tick(); rst = 1'b0; aout(3'd0, 2'd1); expect_v("postinc0", S_ABUS, 16'h8000);
    tick(); aout(3'd0, 2'd1); expect_v("postinc1", S_ABUS, 16'h8001);
    tick(); aout(3'd0, 2'd1); expect_v("postinc2", S_ABUS, 16'h8002);
    tick(); expect_v("pc_after_inc", S_PC, 16'h8003); expect_v("idle_abus_z", S_ABUS, 16'hffff);

    for (int i = 1; i < 6; i++) begin
      tick(); aout(3'(i), 2'd0); mout(3'(i), i[0]);
      expect_v("rst_reg_abus", S_ABUS, 16'h0000);
      expect_v("rst_reg_mbus", S_MBUS, 16'h0000);
    end

    // Reset asserted mid-count cancels the pending increment.
    tick(); aout(3'd0, 2'd1); expect_v("precount", S_ABUS, 16'h8003);
    tick(); aout(3'd0, 2'd1); rst = 1'b1;
    expect_v("midrst_pc", S_PC, 16'h8000); expect_v("midrst_abus_z", S_ABUS, 16'hffff);
    tick(); rst = 1'b0;
    expect_v("postrst_pc", S_PC, 16'h8000); expect_v("postrst_wrap", S_WRAP, 16'h0000);

    // Pre-decrement from zero wraps.
    tick(); aout(3'd2, 2'd2); expect_v("predec_drive", S_ABUS, 16'hffff);
    expect_v("predec_wrap_pre", S_WRAP, 16'h0000);
    tick(); aout(3'd2, 2'd0); mout(3'd2, 1'b1);
    expect_v("predec_reg", S_ABUS, 16'hffff); expect_v("predec_hi", S_MBUS, 16'h00ff);
    expect_v("predec_wrap", S_WRAP, {15'h0000, WRAP_ON});
    tick(); aout(3'd2, 2'd1); expect_v("inc_ffff_drive", S_ABUS, 16'hffff);
    tick(); aout(3'd2, 2'd0); expect_v("inc_ffff_wrap", S_ABUS, 16'h0000);

    // Byte loads assemble reg3.
    tick(); mload(3'd3, 1'b0, 8'h34);
    tick(); mload(3'd3, 1'b1, 8'h12);
    tick(); mout(3'd3, 1'b1); aout(3'd3, 2'd0);
    expect_v("r3_hi", S_MBUS, 16'h0012); expect_v("r3_abus", S_ABUS, 16'h1234);
    tick(); mout(3'd3, 1'b0); aout(3'd3, 2'd2);
    expect_v("r3_lo", S_MBUS, 16'h0034); expect_v("r3_predec", S_ABUS, 16'h1233);
    tick(); aout(3'd3, 2'd0); expect_v("r3_after_dec", S_ABUS, 16'h1233);

    // Priority: reg1 full load from reg4 wins over byte load; reg4 counts concurrently.
    tick(); mload(3'd1, 1'b1, 8'h01);
    tick(); mload(3'd4, 1'b1, 8'h20);
    tick(); aout(3'd4, 2'd1); aload_en = 1'b1; aload_sel = 3'd1; mload(3'd1, 1'b0, 8'h55);
    expect_v("conflict_drive", S_ABUS, 16'h2000);
    tick(); aout(3'd1, 2'd0); mout(3'd4, 1'b0);
    expect_v("conflict_r1", S_ABUS, 16'h2000); expect_v("conflict_r4lo", S_MBUS, 16'h0001);
    tick(); aout(3'd1, 2'd1); aload_en = 1'b1; aload_sel = 3'd1;
    expect_v("feedback_drive", S_ABUS, 16'h2000);
    tick(); aout(3'd1, 2'd0); expect_v("feedback_r1", S_ABUS, 16'h2000);
    tick(); aout(3'd5, 2'd1); mload(3'd5, 1'b0, 8'h77);
    expect_v("mload_vs_cnt_drive", S_ABUS, 16'h0000);
    tick(); aout(3'd5, 2'd0); expect_v("mload_vs_cnt_r5", S_ABUS, 16'h0077);

    // Out-of-range selects.
    tick(); aout(3'd7, 2'd0); mout(3'd7, 1'b1);
    expect_v("oor_abus", S_ABUS, 16'h0000); expect_v("oor_mbus", S_MBUS, 16'h0000);
    tick(); aout(3'd7, 2'd2); expect_v("oor_predec", S_ABUS, 16'h0000);
    tick(); aout(3'd0, 2'd0); aload_en = 1'b1; aload_sel = 3'd7; mload(3'd7, 1'b1, 8'haa);
    expect_v("oor_load_drive", S_ABUS, 16'h8000);
    tick(); aout(3'd3, 2'd0); mout(3'd5, 1'b0);
    expect_v("oor_r3", S_ABUS, 16'h1233); expect_v("oor_r5", S_MBUS, 16'h0077);
    expect_v("oor_pc", S_PC, 16'h8000);

    // Mode 3: silent increment, bus released.
    tick(); aout(3'd0, 2'd3);
    expect_v("inc_only_z", S_ABUS, 16'hffff); expect_v("inc_only_pc_pre", S_PC, 16'h8000);
    tick();
    expect_v("inc_only_pc", S_PC, 16'h8001);
    expect_v("final_wrap", S_WRAP, {15'h0000, WRAP_ON});
    tick();
    tick();

    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
